// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cpu55 unified memory-port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW          = 32;
    localparam int DEF_DW          = 32;
    localparam int DEF_STARVE_MAX  = 4;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } arb_gnt_e;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the fetch, data and memory-side handshakes of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding CPU/memory.
interface mem_bus_arbiter_if #(
    parameter int AW = mem_arb_pkg::DEF_AW,
    parameter int DW = mem_arb_pkg::DEF_DW
) ();

    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_ack;
    logic [DW-1:0]   i_rdata;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_ack;
    logic [DW-1:0]   d_rdata;

    logic            err;

    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_ack;
    logic [DW-1:0]   mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, d_ack, d_rdata, err,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, d_ack, d_rdata, err,
               mem_req, mem_we, mem_be, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_bus_arbiter_starve_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !limit_hit) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign limit_hit = (cnt == CW'(STARVE_MAX));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the cpu55 fetch (I) and data (D) requesters onto one memory port.
// Optional ARB_TIMEOUT_EN aborts a stalled memory access with err after TIMEOUT_CYC cycles.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
`ifdef ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
`endif
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic             clk,
    input  logic             rst,
    mem_bus_arbiter_if.slave bus
);

    localparam int BW = DW / 8;

    arb_state_e    state_q, state_n;
    arb_gnt_e      gnt;
    logic          mem_req_q, mem_req_n;
    logic          mem_we_q, mem_we_n;
    logic [BW-1:0] mem_be_q, mem_be_n;
    logic [AW-1:0] mem_addr_q, mem_addr_n;
    logic [DW-1:0] mem_wdata_q, mem_wdata_n;
    logic          i_ack_q, i_ack_n;
    logic          d_ack_q, d_ack_n;
    logic [DW-1:0] i_rdata_q, i_rdata_n;
    logic [DW-1:0] d_rdata_q, d_rdata_n;
    logic          starve_inc, starve_clr, starve_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    logic [WW-1:0] wait_q, wait_n;
    logic          err_q, err_n;
    logic          timeout;

    assign timeout = (wait_q == WW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_n;
            err_q  <= err_n;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    arb_starve_ctr #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (starve_inc),
        .clr       (starve_clr),
        .limit_hit (starve_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_n;
            mem_req_q   <= mem_req_n;
            mem_we_q    <= mem_we_n;
            mem_be_q    <= mem_be_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            i_ack_q     <= i_ack_n;
            d_ack_q     <= d_ack_n;
            i_rdata_q   <= i_rdata_n;
            d_rdata_q   <= d_rdata_n;
        end
    end

    // Every output register gets its next value here, so acks and mem_req are
    // set on the transition into the state that presents them.
    always_comb begin
        state_n     = state_q;
        mem_req_n   = mem_req_q;
        mem_we_n    = mem_we_q;
        mem_be_n    = mem_be_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        i_ack_n     = 1'b0;
        d_ack_n     = 1'b0;
        i_rdata_n   = i_rdata_q;
        d_rdata_n   = d_rdata_q;
        starve_inc  = 1'b0;
        starve_clr  = 1'b0;
        gnt         = (bus.d_req && !(bus.i_req && starve_hit)) ? GNT_D : GNT_I;
`ifdef ARB_TIMEOUT_EN
        wait_n      = wait_q;
        err_n       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_req_n = 1'b0;
                if (bus.d_req || bus.i_req) begin
                    mem_req_n = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    wait_n    = '0;
`endif
                    if (gnt == GNT_D) begin
                        state_n     = ST_BUSY_D;
                        mem_we_n    = bus.d_we;
                        mem_be_n    = bus.d_be;
                        mem_addr_n  = bus.d_addr;
                        mem_wdata_n = bus.d_wdata;
                        starve_inc  = bus.i_req;
                        starve_clr  = !bus.i_req;
                    end else begin
                        state_n     = ST_BUSY_I;
                        mem_we_n    = 1'b0;
                        mem_be_n    = '1;
                        mem_addr_n  = bus.i_addr;
                        starve_clr  = 1'b1;
                    end
                end
            end
            ST_BUSY_I, ST_BUSY_D: begin
                if (bus.mem_ack) begin
                    state_n   = ST_RESP;
                    mem_req_n = 1'b0;
                    if (state_q == ST_BUSY_I) begin
                        i_ack_n   = 1'b1;
                        i_rdata_n = bus.mem_rdata;
                    end else begin
                        d_ack_n = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_n = bus.mem_rdata;
                        end
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (timeout) begin
                    state_n   = ST_RESP;
                    mem_req_n = 1'b0;
                    err_n     = 1'b1;
                    if (state_q == ST_BUSY_I) begin
                        i_ack_n   = 1'b1;
                        i_rdata_n = '0;
                    end else begin
                        d_ack_n   = 1'b1;
                        d_rdata_n = '0;
                    end
                end else begin
                    wait_n = wait_q + WW'(1);
                end
`endif
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_ack     = i_ack_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed transactions push expected grants
// and responses; independent monitors pop and compare as the DUT presents them.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        side;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_wdata;
    } gnt_t;

    resp_t       resp_q[$];
    gnt_t        gnt_q[$];
    resp_t       mon_e;
    gnt_t        cur_g;
    int          total = 0;
    int          bad = 0;
    int          mem_wait = 0;
    logic [31:0] mem_data = 32'h0;
    logic        stray_ack = 1'b0;
    logic [31:0] d_model = 32'h0;
    int          run = 0;
    int          last_run = 0;
    logic        prev_req = 1'b0;
    logic [68:0] held;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr, input logic dreq,
                                 input logic dwe, input logic [3:0] dbe,
                                 input logic [31:0] daddr, input logic [31:0] dwdata);
        bus.i_req   = ireq;
        bus.i_addr  = iaddr;
        bus.d_req   = dreq;
        bus.d_we    = dwe;
        bus.d_be    = dbe;
        bus.d_addr  = daddr;
        bus.d_wdata = dwdata;
    endtask

    // Expected D read data is whatever the memory model returns; writes leave d_rdata alone.
    task automatic pushD(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        gnt_q.push_back('{we, be, addr, wdata, 1'b1});
        resp_q.push_back('{1'b1, we ? d_model : mem_data, 1'b0});
        if (!we) d_model = mem_data;
    endtask

    task automatic pushI(input logic [31:0] addr);
        gnt_q.push_back('{1'b0, 4'hF, addr, 32'h0, 1'b0});
        resp_q.push_back('{1'b0, mem_data, 1'b0});
    endtask

    task automatic waitAck(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: no ack within %0d cycles, required one", name, max_cyc);
        end
    endtask

    task automatic waitReq(input string name, input int max_cyc);
        bit seen = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: mem_req not seen within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic waitIdle(input string name, input int max_cyc);
        bit done = 1'b0;
        for (int n = 0; n < max_cyc; n++) begin
            @(negedge clk);
            #1;
            if (resp_q.size() == 0 && gnt_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL %s: %0d responses and %0d grants still outstanding, required 0",
                     name, resp_q.size(), gnt_q.size());
            resp_q.delete();
            gnt_q.delete();
        end
    endtask

    // Memory model: acks in the (mem_wait+1)-th cycle of a request; mem_wait<0 never acks.
    initial begin
        int busy_cnt;
        logic ack;
        busy_cnt      = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req) begin
                busy_cnt++;
                ack = (mem_wait >= 0) && (busy_cnt == mem_wait + 1);
            end else begin
                busy_cnt = 0;
                ack      = 1'b0;
            end
            bus.mem_ack   = ack || stray_ack;
            bus.mem_rdata = ack ? mem_data : 32'h0;
        end
    end

    // Response monitor.
    always @(negedge clk) begin
        if (bus.i_ack || bus.d_ack) begin
            if (resp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_ack: i_ack=%0b d_ack=%0b, required none",
                         bus.i_ack, bus.d_ack);
            end else begin
                mon_e = resp_q.pop_front();
                checkOutput("ack_side", {31'b0, bus.d_ack}, {31'b0, mon_e.side});
                checkOutput("ack_both", {31'b0, bus.i_ack & bus.d_ack}, 32'h0);
                if (mon_e.side) checkOutput("d_rdata", bus.d_rdata, mon_e.rdata);
                else            checkOutput("i_rdata", bus.i_rdata, mon_e.rdata);
                checkOutput("ack_err", {31'b0, bus.err}, {31'b0, mon_e.err});
            end
        end
    end

    // Grant monitor: checks each new memory request and that it stays stable.
    always @(negedge clk) begin
        if (bus.mem_req) begin
            if (!prev_req) begin
                run  = 1;
                held = {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
                if (gnt_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_grant: mem_addr=0x%08h, required no request",
                             bus.mem_addr);
                end else begin
                    cur_g = gnt_q.pop_front();
                    checkOutput("mem_we", {31'b0, bus.mem_we}, {31'b0, cur_g.we});
                    checkOutput("mem_be", {28'b0, bus.mem_be}, {28'b0, cur_g.be});
                    checkOutput("mem_addr", bus.mem_addr, cur_g.addr);
                    if (cur_g.chk_wdata) checkOutput("mem_wdata", bus.mem_wdata, cur_g.wdata);
                end
            end else begin
                run++;
                checkOutput("hold_mem_addr", bus.mem_addr, held[63:32]);
                checkOutput("hold_mem_ctl", {bus.mem_we, bus.mem_be, bus.mem_wdata[26:0]},
                            {held[68], held[67:64], held[26:0]});
            end
        end else if (prev_req) begin
            last_run = run;
        end
        prev_req = bus.mem_req;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int gap;
        int acks;
        int high_cnt;
        logic err_seen;

        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("rst_i_ack", {31'b0, bus.i_ack}, 32'h0);
        checkOutput("rst_d_ack", {31'b0, bus.d_ack}, 32'h0);
        checkOutput("rst_err", {31'b0, bus.err}, 32'h0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("rst_mem_be", {28'b0, bus.mem_be}, 32'h0);
        checkOutput("rst_d_rdata", bus.d_rdata, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] single fetch");
        mem_wait = 1;
        mem_data = 32'h2002000A;
        pushI(32'h100);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitAck("fetch_ack", 20);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitIdle("fetch_drain", 20);
        checkOutput("fetch_req_len", 32'(last_run), 32'd2);
        checkOutput("fetch_i_rdata_hold", bus.i_rdata, 32'h2002000A);

        $display("[TB] back-to-back data reads");
        mem_wait = 0;
        mem_data = 32'h00005A5A;
        pushD(1'b0, 4'hF, 32'h300, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h300, 32'h0);
        waitAck("b2b_ack1", 20);
        pushD(1'b0, 4'hF, 32'h304, 32'h0);
        bus.d_addr = 32'h304;
        gap = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            gap++;
            if (bus.mem_req) break;
        end
        checkOutput("b2b_gap", 32'(gap), 32'd2);
        waitAck("b2b_ack2", 20);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitIdle("b2b_drain", 20);

        $display("[TB] data write with inputs changing mid-access");
        mem_wait = 2;
        mem_data = 32'hFFFF0000;
        pushD(1'b1, 4'b0011, 32'h40, 32'hDEADBEEF);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h40, 32'hDEADBEEF);
        waitReq("wr_req", 10);
        bus.d_addr  = 32'h44;
        bus.d_wdata = 32'h0;
        bus.d_be    = 4'hC;
        waitAck("wr_ack", 20);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitIdle("wr_drain", 20);
        checkOutput("wr_req_len", 32'(last_run), 32'd3);
        checkOutput("wr_d_rdata_kept", bus.d_rdata, 32'h00005A5A);

        $display("[TB] stray mem_ack while idle");
        @(posedge clk);
        stray_ack = 1'b1;
        @(posedge clk);
        #2 stray_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("stray_mem_req", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("stray_d_rdata", bus.d_rdata, 32'h00005A5A);
        checkOutput("stray_i_rdata", bus.i_rdata, 32'h2002000A);

        $display("[TB] reset in second busy cycle");
        mem_wait = -1;
        gnt_q.push_back('{1'b0, 4'hF, 32'h500, 32'h0, 1'b1});
        applyStimulus(1'b1, 32'h600, 1'b1, 1'b0, 4'hF, 32'h500, 32'h0);
        waitReq("rst_mid_req", 10);
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        d_model = 32'h0;
        @(negedge clk);
        checkOutput("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'h0);
        checkOutput("rst_mid_d_ack", {31'b0, bus.d_ack}, 32'h0);
        checkOutput("rst_mid_d_rdata", bus.d_rdata, 32'h0);
        repeat (4) @(negedge clk);
        checkOutput("rst_mid_idle", {31'b0, bus.mem_req}, 32'h0);

        $display("[TB] contention with starvation limit");
        mem_wait = 0;
        mem_data = 32'h0C0C0C0C;
        for (int k = 0; k < 10; k++) begin
            if (k % 5 == 4) pushI(32'h1000);
            else            pushD(1'b0, 4'hF, 32'h2000, 32'h0);
        end
        applyStimulus(1'b1, 32'h1000, 1'b1, 1'b0, 4'hF, 32'h2000, 32'h0);
        acks = 0;
        for (int n = 0; n < 200 && acks < 10; n++) begin
            @(negedge clk);
            if (bus.i_ack || bus.d_ack) acks++;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        checkOutput("cont_acks", 32'(acks), 32'd10);
        waitIdle("cont_drain", 20);

        $display("[TB] fetch after contention");
        mem_wait = 0;
        mem_data = 32'h13579BDF;
        pushI(32'h200);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitAck("fetch2_ack", 20);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitIdle("fetch2_drain", 20);
        checkOutput("fetch2_d_rdata_kept", bus.d_rdata, 32'h0C0C0C0C);

        $display("[TB] memory never acknowledges");
        mem_wait = -1;
`ifdef ARB_TIMEOUT_EN
        gnt_q.push_back('{1'b0, 4'hF, 32'h700, 32'h0, 1'b1});
        resp_q.push_back('{1'b1, 32'h0, 1'b1});
        d_model = 32'h0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
        waitAck("to_ack", 40);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        waitIdle("to_drain", 20);
        checkOutput("to_req_len", 32'(last_run), 32'd16);
        checkOutput("to_d_rdata", bus.d_rdata, 32'h0);
        checkOutput("to_err_clear", {31'b0, bus.err}, 32'h0);
`else
        gnt_q.push_back('{1'b0, 4'hF, 32'h700, 32'h0, 1'b1});
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
        waitReq("nto_req", 10);
        high_cnt = 0;
        err_seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (bus.mem_req) high_cnt++;
            if (bus.err) err_seen = 1'b1;
        end
        checkOutput("nto_req_high", 32'(high_cnt), 32'd100);
        checkOutput("nto_err", {31'b0, err_seen}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        d_model = 32'h0;
        @(negedge clk);
        checkOutput("nto_rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
`endif
        repeat (3) @(negedge clk);
        checkOutput("final_queues", 32'(resp_q.size() + gnt_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
